// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply/divide sequencer for the execute stage.
// Steps the shared 32-bit combinational ALU one operation per cycle:
// shift-and-add multiply (ADD) and restoring division (SLT, then SUB).
// Optional feature macro: MULDIV_EARLY_EXIT_EN lets MULTU finish as soon
// as the remaining multiplier bits are all zero.
module muldiv_sequencer #(
  parameter int bits = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            op,
  input  logic [bits-1:0] a,
  input  logic [bits-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [bits-1:0] result_lo,
  output logic [bits-1:0] result_hi,
  output logic            div_by_zero,
  output logic [bits-1:0] alu_op1,
  output logic [bits-1:0] alu_op2,
  output logic [3:0]      alu_control,
  input  logic [bits-1:0] alu_result
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam int CW = (bits > 1) ? $clog2(bits) : 1;
  localparam logic [CW-1:0] LAST = CW'(bits - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV_CMP, S_DIV_SUB, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [bits-1:0] mcand_q, mplr_q, dvsr_q, acc_q, quo_q;
  logic [bits-1:0] shifted;
  logic            carry, ge, last, mul_exit, zero_b;

  // Partial remainder shifted left with the next dividend bit; carry is the
  // bit pushed out of R, which makes the trial value >= divisor regardless.
  assign shifted = {acc_q[bits-2:0], quo_q[bits-1]};
  assign carry   = acc_q[bits-1];
  assign ge      = carry | ~alu_result[0];
  assign last    = (cnt_q == LAST);
  assign zero_b  = (b == '0);
`ifdef MULDIV_EARLY_EXIT_EN
  assign mul_exit = (mplr_q[bits-1:1] == '0);
`else
  assign mul_exit = last;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op) begin
            state_d = zero_b ? S_DONE : S_DIV_CMP;
          end else begin
`ifdef MULDIV_EARLY_EXIT_EN
            state_d = zero_b ? S_DONE : S_MUL;
`else
            state_d = S_MUL;
`endif
          end
        end
      end
      S_MUL:     if (mul_exit) state_d = S_DONE;
      S_DIV_CMP: begin
        if (ge)        state_d = S_DIV_SUB;
        else if (last) state_d = S_DONE;
      end
      S_DIV_SUB: state_d = last ? S_DONE : S_DIV_CMP;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Handshake and ALU drive decoded from registered state only.
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    alu_op1     = '0;
    alu_op2     = '0;
    alu_control = ALU_ADD;
    case (state_q)
      S_MUL: begin
        alu_op1 = acc_q;
        alu_op2 = mplr_q[0] ? mcand_q : '0;
      end
      S_DIV_CMP: begin
        alu_op1     = shifted;
        alu_op2     = dvsr_q;
        alu_control = ALU_SLT;
      end
      S_DIV_SUB: begin
        alu_op1     = acc_q;
        alu_op2     = dvsr_q;
        alu_control = ALU_SUB;
      end
      default: ;
    endcase
  end

  // Operand/accumulator datapath; no reset needed, every value is loaded on start.
  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_q <= a;
          mplr_q  <= b;
          dvsr_q  <= b;
          acc_q   <= '0;
          quo_q   <= a;
        end
      end
      S_MUL: begin
        acc_q   <= alu_result;
        mcand_q <= mcand_q << 1;
        mplr_q  <= mplr_q >> 1;
      end
      S_DIV_CMP: begin
        // R takes the trial value either way; DIV_SUB subtracts from it.
        acc_q <= shifted;
        if (!ge) quo_q <= {quo_q[bits-2:0], 1'b0};
      end
      S_DIV_SUB: begin
        acc_q <= alu_result;
        quo_q <= {quo_q[bits-2:0], 1'b1};
      end
      default: ;
    endcase
  end

  // Iteration counter and held results, written on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q       <= '0;
            div_by_zero <= op & zero_b;
            if (op && zero_b) begin
              result_lo <= '1;
              result_hi <= a;
            end
`ifdef MULDIV_EARLY_EXIT_EN
            if (!op && zero_b) begin
              result_lo <= '0;
              result_hi <= '0;
            end
`endif
          end
        end
        S_MUL: begin
          cnt_q <= cnt_q + CW'(1);
          if (mul_exit) begin
            result_lo <= alu_result;
            result_hi <= '0;
          end
        end
        S_DIV_CMP: begin
          if (!ge) begin
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
              result_lo <= {quo_q[bits-2:0], 1'b0};
              result_hi <= shifted;
            end
          end
        end
        S_DIV_SUB: begin
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            result_lo <= {quo_q[bits-2:0], 1'b1};
            result_hi <= alu_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: a behavioural ALU closes the loop,
// and expected results/latencies come from plain arithmetic on the operands.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, start, op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result_lo, result_hi, alu_op1, alu_op2, alu_result;
  logic [3:0]   alu_control;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.bits(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .div_by_zero(div_by_zero), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_control(alu_control), .alu_result(alu_result)
  );

  // Combinational ALU the sequencer drives; compare is unsigned.
  always_comb begin
    case (alu_control)
      4'b0010: alu_result = alu_op1 + alu_op2;
      4'b0110: alu_result = alu_op1 - alu_op2;
      4'b0111: alu_result = {{(W-1){1'b0}}, (alu_op1 < alu_op2)};
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Edges after the sampling edge until done is seen; a start that goes
  // straight to DONE raises done on the sampling edge itself (0 extra edges).
  function automatic int exp_lat(input bit o, input logic [W-1:0] x, input logic [W-1:0] y);
    if (o) return (y == 0) ? 0 : W + $countones(x / y);
`ifdef MULDIV_EARLY_EXIT_EN
    if (y == 0) return 0;
    for (int i = W - 1; i >= 0; i--) if (y[i]) return i + 1;
`endif
    return W;
  endfunction

  task automatic chk_reset_vals(input string where);
    chk({where, "_busy"}, 64'(busy), 64'(0));
    chk({where, "_done"}, 64'(done), 64'(0));
    chk({where, "_lo"}, 64'(result_lo), 64'(0));
    chk({where, "_hi"}, 64'(result_hi), 64'(0));
    chk({where, "_dbz"}, 64'(div_by_zero), 64'(0));
    chk({where, "_op1"}, 64'(alu_op1), 64'(0));
    chk({where, "_op2"}, 64'(alu_op2), 64'(0));
    chk({where, "_ctl"}, 64'(alu_control), 64'(4'b0010));
  endtask

  // One complete operation; poke pulses a foreign start mid-run and in DONE.
  task automatic run_op(input bit o, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    logic [W-1:0] e_lo, e_hi;
    logic         e_dbz;
    logic [63:0]  prod;
    int           e_lat, n;
    prod = 64'(x) * 64'(y);
    if (o) begin
      if (y == 0) begin e_lo = '1; e_hi = x; e_dbz = 1'b1; end
      else begin e_lo = x / y; e_hi = x % y; e_dbz = 1'b0; end
    end else begin
      e_lo = prod[W-1:0]; e_hi = '0; e_dbz = 1'b0;
    end
    e_lat = exp_lat(o, x, y);

    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = ~o;
    chk("busy_rise", 64'(busy), 64'(1));
    chk("dbz_start", 64'(div_by_zero), 64'(e_dbz));

    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 2) begin
        start = 1'b1; op = ~o; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    chk("done_seen", 64'(done), 64'(1));
    chk("latency", 64'(n), 64'(e_lat));
    chk("result_lo", 64'(result_lo), 64'(e_lo));
    chk("result_hi", 64'(result_hi), 64'(e_hi));
    chk("div_by_zero", 64'(div_by_zero), 64'(e_dbz));

    if (poke) begin
      start = 1'b1; op = ~o; a = $urandom; b = $urandom;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", 64'(done), 64'(0));
    chk("busy_fall", 64'(busy), 64'(0));
    chk("hold_lo", 64'(result_lo), 64'(e_lo));
    chk("hold_hi", 64'(result_hi), 64'(e_hi));
    chk("alu_idle_ops", 64'({alu_op1, alu_op2}), 64'(0));
    chk("alu_idle_ctl", 64'(alu_control), 64'(4'b0010));
  endtask

  initial begin
    int done_seen;
    logic [W-1:0] rx, ry;
    bit ro;

    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("idle");

    // Directed operations.
    run_op(1'b0, 32'd7, 32'd6, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(1'b1, 32'd100, 32'd7, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(1'b1, 32'd5, 32'd0, 1'b0);
    run_op(1'b0, 32'd3, 32'd4, 1'b0);
    run_op(1'b0, 32'd1234, 32'd5678, 1'b1);
    run_op(1'b1, 32'd987654, 32'd321, 1'b1);
    run_op(1'b0, 32'd5, 32'd3, 1'b0);
    run_op(1'b0, 32'd9, 32'd0, 1'b0);
    run_op(1'b1, 32'd3, 32'd10, 1'b0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 12; i++) begin
      ro = 1'($urandom_range(0, 1));
      rx = $urandom;
      case ($urandom_range(0, 3))
        0:       ry = '0;
        1:       ry = W'($urandom_range(1, 255));
        default: ry = $urandom;
      endcase
      run_op(ro, rx, ry, 1'b0);
    end

    // Reset in the middle of a division: abandoned with no done pulse.
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    chk("no_done_after_reset", 64'(done_seen), 64'(0));
    chk("idle_after_reset", 64'(busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
